// File: rtl/me266_pkg.sv
// me266_pkg: shared definitions for the me266 result link transmit stage.
// Holds default widths, frame length, the serializer FSM state encoding and
// the parallel result record layout {sad, x, y}.
// Optional feature macro: ME_RES_PARITY_EN (adds one even-parity cycle per frame).
package me266_pkg;

   localparam int unsigned SAD_W_DEF = 14;
   localparam int unsigned MV_W_DEF  = 4;

`ifdef ME_RES_PARITY_EN
   localparam int unsigned PAR_LEN = 1;
`else
   localparam int unsigned PAR_LEN = 0;
`endif

   localparam int unsigned FRAME_LEN = SAD_W_DEF + PAR_LEN;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } me_state_e;

   typedef struct packed {
      logic [SAD_W_DEF-1:0] sad;
      logic [MV_W_DEF-1:0]  x;
      logic [MV_W_DEF-1:0]  y;
   } me_res_t;

endpackage

// File: rtl/me_res_fifo.sv
// me_res_fifo: synchronous FIFO for parallel result records.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push, pop  write / read strobes (ignored when full / empty)
//   din, dout  record in, head record out (combinational read of head)
//   full,empty registered status flags
module me_res_fifo #(
   parameter int unsigned W     = 22,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [AW:0]  w_wr_nxt;
   logic [AW:0]  w_rd_nxt;
   logic         r_full;
   logic         r_empty;
   logic         w_push;
   logic         w_pop;

   assign w_push   = push && !r_full;
   assign w_pop    = pop && !r_empty;
   assign w_wr_nxt = r_wr_ptr + (AW+1)'(w_push);
   assign w_rd_nxt = r_rd_ptr + (AW+1)'(w_pop);

   // Flags are computed from the next pointers so they are true flops;
   // the extra pointer MSB separates full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_empty  <= (w_wr_nxt == w_rd_nxt);
         r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                     (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = r_mem[r_rd_ptr[AW-1:0]];
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/me_result_serializer.sv
// me_result_serializer: transmit end of the me266 1-bit result link.
// Buffers {sad, x, y} results and shifts each out as one framed burst.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   res_valid/res_ready   result handshake (ready = FIFO not full)
//   res_sad, res_x, res_y parallel result
//   sign_sad              frame-active strobe
//   sad_out, x_out, y_out serial data, MSB first, 0 outside a frame
//   busy                  FIFO non-empty or frame/gap in progress
// Optional feature macro: ME_RES_PARITY_EN (one extra even-parity cycle).
module me_result_serializer
   import me266_pkg::*;
#(
   parameter int unsigned SAD_W      = SAD_W_DEF,
   parameter int unsigned MV_W       = MV_W_DEF,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [SAD_W-1:0] res_sad,
   input  logic [MV_W-1:0]  res_x,
   input  logic [MV_W-1:0]  res_y,
   output logic             sign_sad,
   output logic             sad_out,
   output logic             x_out,
   output logic             y_out,
   output logic             busy
);

   localparam int unsigned FRM_LEN = SAD_W + PAR_LEN;
   localparam int unsigned REC_W   = SAD_W + 2*MV_W;
   localparam int unsigned BIT_W   = $clog2(FRM_LEN);
   localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   me_state_e        r_state;
   me_state_e        w_state_nxt;
   logic [BIT_W-1:0] r_bit;
   logic [GAP_W-1:0] r_gap;
   logic [SAD_W-1:0] r_sad_sh;
   logic [MV_W-1:0]  r_x_sh;
   logic [MV_W-1:0]  r_y_sh;
   logic             r_sign;
   logic             r_sad_bit;
   logic             r_x_bit;
   logic             r_y_bit;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_last_bit;
   logic             w_gap_done;
   logic [REC_W-1:0] w_head;
   logic [SAD_W-1:0] w_head_sad;
   logic [MV_W-1:0]  w_head_x;
   logic [MV_W-1:0]  w_head_y;
`ifdef ME_RES_PARITY_EN
   logic             r_sad_par;
   logic             r_x_par;
   logic             r_y_par;
`endif

   assign res_ready = !w_full;
   assign w_push    = res_valid && !w_full;

   me_res_fifo #(
      .W     (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({res_sad, res_x, res_y}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign {w_head_sad, w_head_x, w_head_y} = w_head;
   assign w_last_bit = (r_bit == BIT_W'(FRM_LEN-1));
   assign w_gap_done = (r_gap == GAP_W'(GAP_CYCLES-1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (!w_empty) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last_bit) w_state_nxt = ST_GAP;
         ST_GAP:   if (w_gap_done) w_state_nxt = w_empty ? ST_IDLE : ST_SHIFT;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: pop loads the head so its first bit is on the wire next cycle
   always_comb begin
      w_pop = 1'b0;
      busy  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_pop = !w_empty;
            busy  = !w_empty;
         end
         ST_SHIFT: busy = 1'b1;
         ST_GAP: begin
            w_pop = w_gap_done && !w_empty;
            busy  = 1'b1;
         end
         default: ;
      endcase
   end

   // Bit and gap counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit <= '0;
         r_gap <= '0;
      end else begin
         if (w_pop)                   r_bit <= '0;
         else if (r_state == ST_SHIFT) r_bit <= r_bit + 1'b1;
         if (r_state == ST_SHIFT)      r_gap <= '0;
         else if (r_state == ST_GAP)   r_gap <= r_gap + 1'b1;
      end
   end

   // Shift registers hold the bits not yet on the wire; zeros shifted in
   // past MV_W give the trailing 0s on x_out/y_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sad_sh  <= '0;
         r_x_sh    <= '0;
         r_y_sh    <= '0;
         r_sign    <= 1'b0;
         r_sad_bit <= 1'b0;
         r_x_bit   <= 1'b0;
         r_y_bit   <= 1'b0;
`ifdef ME_RES_PARITY_EN
         r_sad_par <= 1'b0;
         r_x_par   <= 1'b0;
         r_y_par   <= 1'b0;
`endif
      end else if (w_pop) begin
         r_sign    <= 1'b1;
         r_sad_bit <= w_head_sad[SAD_W-1];
         r_x_bit   <= w_head_x[MV_W-1];
         r_y_bit   <= w_head_y[MV_W-1];
         r_sad_sh  <= w_head_sad << 1;
         r_x_sh    <= w_head_x << 1;
         r_y_sh    <= w_head_y << 1;
`ifdef ME_RES_PARITY_EN
         r_sad_par <= ^w_head_sad;
         r_x_par   <= ^w_head_x;
         r_y_par   <= ^w_head_y;
`endif
      end else if (r_state == ST_SHIFT && !w_last_bit) begin
         r_sign <= 1'b1;
`ifdef ME_RES_PARITY_EN
         if (r_bit == BIT_W'(SAD_W-1)) begin
            r_sad_bit <= r_sad_par;
            r_x_bit   <= r_x_par;
            r_y_bit   <= r_y_par;
         end else
`endif
         begin
            r_sad_bit <= r_sad_sh[SAD_W-1];
            r_x_bit   <= r_x_sh[MV_W-1];
            r_y_bit   <= r_y_sh[MV_W-1];
            r_sad_sh  <= r_sad_sh << 1;
            r_x_sh    <= r_x_sh << 1;
            r_y_sh    <= r_y_sh << 1;
         end
      end else begin
         r_sign    <= 1'b0;
         r_sad_bit <= 1'b0;
         r_x_bit   <= 1'b0;
         r_y_bit   <= 1'b0;
      end
   end

   assign sign_sad = r_sign;
   assign sad_out  = r_sad_bit;
   assign x_out    = r_x_bit;
   assign y_out    = r_y_bit;

endmodule
